// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants, ALU op codes and the issue FSM state type
//                for the alu_issue block and its register file.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Datapath width and register count; must match the downstream ALU.
  localparam int ALU_W     = 16;
  localparam int ALU_NREGS = 8;
  localparam int ALU_AW    = $clog2(ALU_NREGS);

  // ALU select codes. Codes 7..15 are not decoded; the ALU returns 0.
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOTA = 4'd5;
  localparam logic [3:0] OP_NOTB = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : alu_regfile
//  Description : NREGS x W register file, two combinational read ports and one
//                synchronous write port. Register 0 reads as zero and ignores
//                writes. Asynchronous active-high reset clears all registers.
//  Ports       : clk, rst          clock / async reset
//                i_ra1, i_ra2      read addresses
//                o_rd1, o_rd2      read data (combinational)
//                i_we, i_wa, i_wd  write enable / address / data
//  Revision    : 1.0  initial release
// ============================================================================
module alu_regfile
  import alu_pkg::*;
#(
  parameter  int W     = ALU_W,
  parameter  int NREGS = ALU_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_ra1,
  input  logic [AW-1:0] i_ra2,
  output logic [W-1:0]  o_rd1,
  output logic [W-1:0]  o_rd2,
  input  logic          i_we,
  input  logic [AW-1:0] i_wa,
  input  logic [W-1:0]  i_wd
);

  logic [W-1:0] w_regs [NREGS];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
    if (gi == 0) begin : g_zero
      // r0 is hardwired: no storage, writes have nowhere to land.
      assign w_regs[gi] = '0;
    end else begin : g_store
      logic [W-1:0] reg_q;
      logic [W-1:0] reg_d;

      always_comb begin
        reg_d = reg_q;
        if (i_we && (i_wa == AW'(gi))) begin
          reg_d = i_wd;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign w_regs[gi] = reg_q;
    end
  end

  assign o_rd1 = w_regs[i_ra1];
  assign o_rd2 = w_regs[i_ra2];

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : Issue / writeback stage in front of a 16-bit combinational
//                ALU. Accepts one instruction at a time over valid/ready,
//                reads operands from an internal register file (with a bypass
//                from the retiring result), holds the ALU inputs stable for
//                one EXEC cycle, captures the result and writes it back in WB.
//  Ports       : clk, rst                      clock / async active-high reset
//                instr_valid / instr_ready     instruction handshake
//                instr_op, instr_rd, instr_rs1, instr_rs2,
//                instr_imm_en, instr_imm       instruction fields
//                alu_a, alu_b, alu_sel         registered ALU inputs
//                alu_out, alu_carry            ALU results
//                wb_valid, wb_rd, wb_data      retirement pulse / dest / data
//                busy                          high in EXEC and WB
//                carry_flag                    carry of last retired op
//  Config      : ALU_ISSUE_CARRY_FLAG_EN  defined -> carry_flag is a register
//                updated in every WB cycle; undefined -> carry_flag tied to 0
//                and alu_carry is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue
  import alu_pkg::*;
#(
  parameter  int W     = ALU_W,
  parameter  int NREGS = ALU_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  input  logic          instr_imm_en,
  input  logic [W-1:0]  instr_imm,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_sel,
  input  logic [W-1:0]  alu_out,
  input  logic          alu_carry,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [W-1:0]  wb_data,
  output logic          busy,
  output logic          carry_flag
);

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [3:0]    sel_q, sel_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [W-1:0]  res_q, res_d;

  logic          w_hs;
  logic          w_in_wb;
  logic [W-1:0]  w_rf_rd1;
  logic [W-1:0]  w_rf_rd2;
  logic          w_byp1;
  logic          w_byp2;
  logic [W-1:0]  w_src1;
  logic [W-1:0]  w_src2;

  alu_regfile #(
    .W     (W),
    .NREGS (NREGS)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (instr_rs1),
    .i_ra2 (instr_rs2),
    .o_rd1 (w_rf_rd1),
    .o_rd2 (w_rf_rd2),
    .i_we  (w_in_wb),
    .i_wa  (rd_q),
    .i_wd  (res_q)
  );

  assign w_in_wb     = (state_q == WB);
  assign instr_ready = (state_q != EXEC);
  assign busy        = (state_q != IDLE);
  assign wb_valid    = w_in_wb;
  assign w_hs        = instr_valid && instr_ready;

  // The array write of the retiring result lands at the end of WB, so an
  // instruction accepted in that same cycle must take res_q directly.
  // r0 is excluded: its "result" is never stored and must still read 0.
  assign w_byp1 = w_in_wb && (rd_q != '0) && (instr_rs1 == rd_q);
  assign w_byp2 = w_in_wb && (rd_q != '0) && (instr_rs2 == rd_q);
  assign w_src1 = w_byp1 ? res_q : w_rf_rd1;
  assign w_src2 = w_byp2 ? res_q : w_rf_rd2;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    res_d   = res_q;

    case (state_q)
      IDLE: begin
        if (w_hs) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = WB;
        res_d   = alu_out;
      end
      WB: begin
        state_d = w_hs ? EXEC : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (w_hs) begin
      a_d   = w_src1;
      b_d   = instr_imm_en ? instr_imm : w_src2;
      sel_d = instr_op;
      rd_d  = instr_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
    end
  end

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_sel = sel_q;
  assign wb_rd   = rd_q;
  assign wb_data = res_q;

`ifdef ALU_ISSUE_CARRY_FLAG_EN
  logic cy_q, cy_d;
  logic flag_q, flag_d;

  always_comb begin
    cy_d   = cy_q;
    flag_d = flag_q;
    if (state_q == EXEC) begin
      cy_d = alu_carry;
    end
    if (w_in_wb) begin
      flag_d = cy_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cy_q   <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      cy_q   <= cy_d;
      flag_q <= flag_d;
    end
  end

  assign carry_flag = flag_q;
`else
  // Carry tracking is compiled out; the input stays on the port list.
  logic w_unused_carry;
  assign w_unused_carry = alu_carry;
  assign carry_flag     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue
//  Description : Self-checking bench for alu_issue. Provides a behavioural
//                16-bit ALU on the DUT's ALU ports and a register-array model
//                of the architectural state; directed scenarios plus a
//                randomized instruction stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue;
  import alu_pkg::*;

`ifdef ALU_ISSUE_CARRY_FLAG_EN
  localparam bit c_flag_en = 1'b1;
`else
  localparam bit c_flag_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [2:0]  instr_rd, instr_rs1, instr_rs2;
  logic        instr_imm_en;
  logic [15:0] instr_imm;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_out;
  logic        alu_carry;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        busy;
  logic        carry_flag;

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_r [8];
  logic        exp_flag;
  logic [15:0] last_wb;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_rd     (instr_rd),
    .instr_rs1    (instr_rs1),
    .instr_rs2    (instr_rs2),
    .instr_imm_en (instr_imm_en),
    .instr_imm    (instr_imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_out      (alu_out),
    .alu_carry    (alu_carry),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .busy         (busy),
    .carry_flag   (carry_flag)
  );

  // Behavioural ALU: {add-carry, result}
  function automatic logic [16:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] op);
    logic [16:0] s;
    logic [15:0] r;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = ~a;
      4'd6:    r = ~b;
      default: r = 16'h0000;
    endcase
    return {s[16], r};
  endfunction

  assign {alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

  task automatic clear_model();
    for (int i = 0; i < 8; i++) ref_r[i] = 16'h0000;
    exp_flag = 1'b0;
  endtask

  // Issue one instruction; entered between edges with the DUT ready, returns
  // #1 after the edge that enters WB (so the next call is back-to-back).
  task automatic send(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                      input bit imm_en, input logic [15:0] imm, input bit junk);
    logic [15:0] ea, eb;
    logic [16:0] r;
    ea = ref_r[rs1];
    eb = imm_en ? imm : ref_r[rs2];
    r  = alu_fn(ea, eb, op);

    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_issue: got %b want 1", instr_ready);
    end
    instr_valid  = 1'b1;
    instr_op     = op;
    instr_rd     = 3'(rd);
    instr_rs1    = 3'(rs1);
    instr_rs2    = 3'(rs2);
    instr_imm_en = imm_en;
    instr_imm    = imm;
    @(posedge clk); #1;

    // Offer a garbage instruction while not ready: it must be ignored.
    instr_valid = junk;
    if (junk) begin
      instr_op  = 4'($urandom);
      instr_rd  = 3'($urandom);
      instr_rs1 = 3'($urandom);
      instr_rs2 = 3'($urandom);
      instr_imm = 16'($urandom);
    end

    checks++;
    if ({alu_a, alu_b, alu_sel, busy, instr_ready, wb_valid, carry_flag} !==
        {ea, eb, op, 1'b1, 1'b0, 1'b0, exp_flag}) begin
      errors++;
      $display("FAIL exec_stage: got a=%h b=%h sel=%0d busy=%b rdy=%b wbv=%b cf=%b want a=%h b=%h sel=%0d busy=1 rdy=0 wbv=0 cf=%b",
               alu_a, alu_b, alu_sel, busy, instr_ready, wb_valid, carry_flag, ea, eb, op, exp_flag);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;

    checks++;
    if ({wb_valid, wb_rd, wb_data, busy, instr_ready, carry_flag, alu_a, alu_b} !==
        {1'b1, 3'(rd), r[15:0], 1'b1, 1'b1, exp_flag, ea, eb}) begin
      errors++;
      $display("FAIL wb_stage: got v=%b rd=%0d data=%h busy=%b rdy=%b cf=%b a=%h b=%h want v=1 rd=%0d data=%h busy=1 rdy=1 cf=%b a=%h b=%h",
               wb_valid, wb_rd, wb_data, busy, instr_ready, carry_flag, alu_a, alu_b,
               rd, r[15:0], exp_flag, ea, eb);
    end
    last_wb = wb_data;
    if (rd != 0) ref_r[rd] = r[15:0];
    if (c_flag_en) exp_flag = r[16];
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      checks++;
      if ({wb_valid, busy, instr_ready, carry_flag} !== {1'b0, 1'b0, 1'b1, exp_flag}) begin
        errors++;
        $display("FAIL idle_state: got wbv=%b busy=%b rdy=%b cf=%b want 0 0 1 %b",
                 wb_valid, busy, instr_ready, carry_flag, exp_flag);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
    instr_imm_en = 1'b0; instr_imm = '0;
    clear_model();
    #12;
    checks++;
    if ({alu_a, alu_b, alu_sel, wb_data, wb_rd, wb_valid, busy, carry_flag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h b=%h sel=%h d=%h rd=%h v=%b busy=%b cf=%b want all 0",
               alu_a, alu_b, alu_sel, wb_data, wb_rd, wb_valid, busy, carry_flag);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({instr_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b busy=%b want 1 0", instr_ready, busy);
    end
  endtask

  task automatic test_load_imm();
    send(OP_ADD, 1, 0, 0, 1'b1, 16'h00FF, 1'b0);
    checks++;
    if (last_wb !== 16'h00FF) begin
      errors++; $display("FAIL load_imm: got %h want 00ff", last_wb);
    end
    idle(1);
    send(OP_ADD, 5, 1, 0, 1'b1, 16'h0000, 1'b0);
    checks++;
    if (last_wb !== 16'h00FF) begin
      errors++; $display("FAIL read_r1: got %h want 00ff", last_wb);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    send(OP_ADD, 1, 0, 0, 1'b1, 16'h00FF, 1'b0);
    send(OP_SUB, 2, 1, 0, 1'b1, 16'h0001, 1'b0);
    checks++;
    if (last_wb !== 16'h00FE) begin
      errors++; $display("FAIL bypass_sub: got %h want 00fe", last_wb);
    end
    // register-register bypass on the rs2 path
    send(OP_SUB, 3, 1, 2, 1'b0, 16'h0000, 1'b1);
    checks++;
    if (last_wb !== 16'h0001) begin
      errors++; $display("FAIL bypass_rs2: got %h want 0001", last_wb);
    end
    idle(1);
  endtask

  task automatic test_carry();
    send(OP_ADD, 1, 0, 0, 1'b1, 16'h0001, 1'b0);
    send(OP_ADD, 2, 0, 0, 1'b1, 16'h00FF, 1'b0);
    idle(1);
    send(OP_ADD, 3, 1, 0, 1'b1, 16'hFFFF, 1'b0);
    checks++;
    if (last_wb !== 16'h0000) begin
      errors++; $display("FAIL carry_sum: got %h want 0000", last_wb);
    end
    idle(1);
    checks++;
    if (carry_flag !== c_flag_en) begin
      errors++; $display("FAIL carry_set: got %b want %b", carry_flag, c_flag_en);
    end
    send(OP_AND, 6, 2, 0, 1'b1, 16'h0F0F, 1'b0);
    checks++;
    if (last_wb !== 16'h000F) begin
      errors++; $display("FAIL and_result: got %h want 000f", last_wb);
    end
    idle(1);
    checks++;
    if (carry_flag !== 1'b0) begin
      errors++; $display("FAIL carry_clear: got %b want 0", carry_flag);
    end
  endtask

  task automatic test_r0_write();
    send(OP_XOR, 0, 0, 0, 1'b1, 16'h1234, 1'b0);
    checks++;
    if (last_wb !== 16'h1234) begin
      errors++; $display("FAIL r0_wb_data: got %h want 1234", last_wb);
    end
    send(OP_OR, 5, 0, 0, 1'b0, 16'h0000, 1'b0);
    checks++;
    if (last_wb !== 16'h0000) begin
      errors++; $display("FAIL r0_read_bypass: got %h want 0000", last_wb);
    end
    idle(1);
    send(OP_OR, 5, 0, 0, 1'b0, 16'h0000, 1'b0);
    checks++;
    if (last_wb !== 16'h0000) begin
      errors++; $display("FAIL r0_read_array: got %h want 0000", last_wb);
    end
    idle(1);
  endtask

  task automatic test_unused_op();
    send(OP_ADD, 1, 0, 0, 1'b1, 16'h00FF, 1'b0);
    send(4'd9, 4, 1, 1, 1'b0, 16'h0000, 1'b0);
    checks++;
    if (last_wb !== 16'h0000) begin
      errors++; $display("FAIL op9: got %h want 0000", last_wb);
    end
    send(OP_NOTA, 7, 1, 0, 1'b1, 16'h0000, 1'b0);
    checks++;
    if (last_wb !== 16'hFF00) begin
      errors++; $display("FAIL nota: got %h want ff00", last_wb);
    end
    idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      send(4'($urandom_range(0, 15)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), 1'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);
  endtask

  task automatic test_reset_mid_exec();
    send(OP_ADD, 4, 0, 0, 1'b1, 16'h0011, 1'b0);
    idle(1);
    instr_valid = 1'b1; instr_op = OP_ADD; instr_rd = 3'd4; instr_rs1 = 3'd0;
    instr_rs2 = 3'd0; instr_imm_en = 1'b1; instr_imm = 16'h5555;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    clear_model();
    checks++;
    if ({alu_a, alu_b, alu_sel, wb_data, wb_rd, wb_valid, busy, carry_flag} !== '0) begin
      errors++;
      $display("FAIL midexec_reset_outputs: got a=%h b=%h sel=%h d=%h rd=%h v=%b busy=%b cf=%b want all 0",
               alu_a, alu_b, alu_sel, wb_data, wb_rd, wb_valid, busy, carry_flag);
    end
    @(negedge clk); rst = 1'b0;
    idle(2);
    send(OP_ADD, 5, 4, 0, 1'b1, 16'h0000, 1'b0);
    checks++;
    if (last_wb !== 16'h0000) begin
      errors++; $display("FAIL r4_after_reset: got %h want 0000", last_wb);
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_load_imm();
    test_back_to_back();
    test_carry();
    test_r0_write();
    test_unused_op();
    test_random();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
